memshare_regfile_mport: RTL and testbench



---
 rtl/memshare_regfile_pkg.sv | 44 ++++
 rtl/memshare_rdport_pipe.sv | 59 +++++
 rtl/memshare_regfile_mport.sv | 68 ++++++
 tb/tb_memshare_regfile_mport.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/memshare_regfile_pkg.sv
// memshare_regfile_pkg: Type-0 word layout, field helpers and shared constants
package memshare_regfile_pkg;

  localparam int T0_SHIFT_W = 3;
  localparam int T0_DELTA_W = 3;
  localparam int T0_W       = T0_SHIFT_W + T0_DELTA_W + 1;
  localparam int SHIFT_LSB  = 0;
  localparam int DELTA_LSB  = T0_SHIFT_W;
  localparam int GTR_BIT    = T0_SHIFT_W + T0_DELTA_W;

  localparam logic [T0_W-1:0] TYPE0_ZERO_WORD = '0;

  typedef struct packed {
    logic                  gtr;
    logic [T0_DELTA_W-1:0] delta;
    logic [T0_SHIFT_W-1:0] shift;
  } type0_t;

  function automatic logic [T0_W-1:0] pack_type0(type0_t f);
    logic [T0_W-1:0] w;
    w = TYPE0_ZERO_WORD;
    w[SHIFT_LSB +: T0_SHIFT_W] = f.shift;
    w[DELTA_LSB +: T0_DELTA_W] = f.delta;
    w[GTR_BIT] = f.gtr;
    return w;
  endfunction

  function automatic type0_t unpack_type0(logic [T0_W-1:0] w);
    type0_t f;
    f.shift = w[SHIFT_LSB +: T0_SHIFT_W];
    f.delta = w[DELTA_LSB +: T0_DELTA_W];
    f.gtr   = w[GTR_BIT];
    return f;
  endfunction

  // Clears only the delta field; shift and isGtr pass through untouched.
  function automatic logic [T0_W-1:0] mask_delta(logic [T0_W-1:0] w, logic flush);
    type0_t f;
    f = unpack_type0(w);
    f.delta = flush ? '0 : f.delta;
    return pack_type0(f);
  endfunction

endpackage

// File: rtl/memshare_rdport_pipe.sv
// memshare_rdport_pipe: one read port -- bypass, range check, fixed-latency pipeline with delta flush
module memshare_rdport_pipe
  import memshare_regfile_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int PAGE_NUM = 32,
  parameter int RD_CYCLE = 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              delta_flush,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [T0_W-1:0]   tap,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [T0_W-1:0]   wdata,
  output logic              vld,
  output logic              err,
  output logic [T0_W-1:0]   word
);

  logic                oor;
  logic [T0_W-1:0]     cap;
  logic [RD_CYCLE-1:0] vld_q, err_q, vin, ein;
  logic [T0_W-1:0]     word_q [RD_CYCLE];
  logic [T0_W-1:0]     win    [RD_CYCLE];

  // Stage inputs: stage 0 takes the captured read (zero word when out of range, write data on a same-edge hit)
  always_comb begin
    oor = int'(addr) >= PAGE_NUM;
    cap = oor ? TYPE0_ZERO_WORD : (we && waddr == addr) ? wdata : tap;
    vin[0] = req;
    ein[0] = req && oor;
    win[0] = cap;
    for (int i = 1; i < RD_CYCLE; i++) begin
      vin[i] = vld_q[i-1];
      ein[i] = err_q[i-1];
      win[i] = word_q[i-1];
    end
  end

  // Each stage loads data only behind a valid, so the output word holds between reads; flush zeroes every delta
  always_ff @(posedge sys_clk)
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < RD_CYCLE; i++) word_q[i] <= TYPE0_ZERO_WORD;
    end else begin
      vld_q <= vin;
      err_q <= ein;
      for (int i = 0; i < RD_CYCLE; i++) word_q[i] <= mask_delta(vin[i] ? win[i] : word_q[i], delta_flush);
    end

  assign vld  = vld_q[RD_CYCLE-1];
  assign err  = err_q[RD_CYCLE-1];
  assign word = word_q[RD_CYCLE-1];

endmodule

// File: rtl/memshare_regfile_mport.sv
// memshare_regfile_mport: multi-port Type-0 L1PA shift/delta register file
module memshare_regfile_mport
  import memshare_regfile_pkg::*;
#(
  parameter int SHIFT_BITWIDTH      = 3,
  parameter int DELTA_BITWIDTH      = 3,
  parameter int SEQ_PTR_BITWIDTH    = 1,
  parameter int TYPE0_ADDR_BITWIDTH = 5,
  parameter int TYPE0_PAGE_NUM      = 32,
  parameter int NUM_RD_PORTS        = 4,
  parameter int REGFILE_RD_CYCLE    = 1,
  localparam int W = SHIFT_BITWIDTH + DELTA_BITWIDTH + 1,
  localparam int A = TYPE0_ADDR_BITWIDTH
) (
  input  logic                                sys_clk,
  input  logic                                rst,
  input  logic                                deltaPipe_rst,
  input  logic [NUM_RD_PORTS-1:0]             rd_req_i,
  input  logic [NUM_RD_PORTS*A-1:0]           rd_addr_i,
  output logic [NUM_RD_PORTS-1:0]             rd_vld_o,
  output logic [NUM_RD_PORTS-1:0]             rd_err_o,
  output logic [NUM_RD_PORTS*SHIFT_BITWIDTH-1:0] l1pa_shift_o,
  output logic [NUM_RD_PORTS*DELTA_BITWIDTH-1:0] shift_delta_o,
  output logic [NUM_RD_PORTS-1:0]             isGtr_o,
  input  logic                                regType0_we_i,
  input  logic [A-1:0]                        regType0_waddr_i,
  input  logic [W-1:0]                        regType0_wdata_i
);

  if (SEQ_PTR_BITWIDTH != 1 || SHIFT_BITWIDTH != T0_SHIFT_W || DELTA_BITWIDTH != T0_DELTA_W ||
      TYPE0_PAGE_NUM > 2**A || NUM_RD_PORTS < 1 || REGFILE_RD_CYCLE < 1) begin : g_bad_cfg
    $error("memshare_regfile_mport: unsupported parameter set");
  end

  logic [T0_W-1:0] mem [TYPE0_PAGE_NUM];

  // Page store: writes outside the implemented pages and writes during reset are dropped
  always_ff @(posedge sys_clk)
    if (!rst && regType0_we_i && int'(regType0_waddr_i) < TYPE0_PAGE_NUM) mem[regType0_waddr_i] <= regType0_wdata_i;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    logic [T0_W-1:0] word;
    type0_t          f;
    memshare_rdport_pipe #(
      .ADDR_W  (A),
      .PAGE_NUM(TYPE0_PAGE_NUM),
      .RD_CYCLE(REGFILE_RD_CYCLE)
    ) u_pipe (
      .sys_clk    (sys_clk),
      .rst        (rst),
      .delta_flush(deltaPipe_rst),
      .req        (rd_req_i[p]),
      .addr       (rd_addr_i[p*A +: A]),
      .tap        (mem[rd_addr_i[p*A +: A]]),
      .we         (regType0_we_i),
      .waddr      (regType0_waddr_i),
      .wdata      (regType0_wdata_i),
      .vld        (rd_vld_o[p]),
      .err        (rd_err_o[p]),
      .word       (word)
    );
    assign f = unpack_type0(word);
    assign l1pa_shift_o[p*SHIFT_BITWIDTH +: SHIFT_BITWIDTH]  = f.shift;
    assign shift_delta_o[p*DELTA_BITWIDTH +: DELTA_BITWIDTH] = f.delta;
    assign isGtr_o[p] = f.gtr;
  end

endmodule

// File: tb/tb_memshare_regfile_mport.sv
// tb_memshare_regfile_mport: scoreboard + table-driven bench for latency-1 and latency-3 instances
module tb_memshare_regfile_mport;

  localparam int P = 4, A = 5, W = 7, PG = 20;

  logic sys_clk = 0;
  always #5 sys_clk = ~sys_clk;

  logic rst = 1, dflush = 0, we = 0;
  logic [P-1:0]   req = '0;
  logic [P*A-1:0] raddr = '0;
  logic [A-1:0]   waddr = '0;
  logic [W-1:0]   wdata = '0;
  logic [P-1:0]   vld1, err1, gt1, vld3, err3, gt3;
  logic [P*3-1:0] sh1, dl1, sh3, dl3;

  memshare_regfile_mport #(.TYPE0_PAGE_NUM(PG), .NUM_RD_PORTS(P), .REGFILE_RD_CYCLE(1)) dut1 (
    .sys_clk(sys_clk), .rst(rst), .deltaPipe_rst(dflush), .rd_req_i(req), .rd_addr_i(raddr),
    .rd_vld_o(vld1), .rd_err_o(err1), .l1pa_shift_o(sh1), .shift_delta_o(dl1), .isGtr_o(gt1),
    .regType0_we_i(we), .regType0_waddr_i(waddr), .regType0_wdata_i(wdata));

  memshare_regfile_mport #(.TYPE0_PAGE_NUM(PG), .NUM_RD_PORTS(P), .REGFILE_RD_CYCLE(3)) dut3 (
    .sys_clk(sys_clk), .rst(rst), .deltaPipe_rst(dflush), .rd_req_i(req), .rd_addr_i(raddr),
    .rd_vld_o(vld3), .rd_err_o(err3), .l1pa_shift_o(sh3), .shift_delta_o(dl3), .isGtr_o(gt3),
    .regType0_we_i(we), .regType0_waddr_i(waddr), .regType0_wdata_i(wdata));

  typedef struct packed {
    logic [P-1:0]   vld;
    logic [P-1:0]   err;
    logic [P*W-1:0] word;
  } rec_t;

  typedef struct {
    logic [P-1:0]   req;
    logic [P*A-1:0] raddr;
    logic           we;
    logic [A-1:0]   waddr;
    logic [W-1:0]   wdata;
    logic           fl;
  } vec_t;

  rec_t q1[$], q3[$];
  rec_t o1 = '0, o3 = '0;
  logic [W-1:0] mem [PG];
  int errors = 0, checks = 0;
  vec_t tbl[10];

  function automatic logic [P*A-1:0] pk(int a0, int a1, int a2, int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic logic [W-1:0] act_word(logic [P*3-1:0] sh, logic [P*3-1:0] dl, logic [P-1:0] gt, int p);
    return {gt[p], dl[p*3 +: 3], sh[p*3 +: 3]};
  endfunction

  function automatic rec_t capture();
    rec_t r;
    logic [A-1:0] a;
    r = '0;
    for (int p = 0; p < P; p++) begin
      a = raddr[p*A +: A];
      r.vld[p] = req[p];
      r.err[p] = req[p] && a >= PG;
      r.word[p*W +: W] = (a >= PG) ? '0 : (we && waddr == a) ? wdata : mem[a];
    end
    return r;
  endfunction

  function automatic rec_t clr(rec_t r);
    for (int p = 0; p < P; p++) r.word[p*W+3 +: 3] = '0;
    return r;
  endfunction

  function automatic rec_t merge(rec_t o, rec_t f);
    o.vld = f.vld;
    o.err = f.err;
    for (int p = 0; p < P; p++) if (f.vld[p]) o.word[p*W +: W] = f.word[p*W +: W];
    return o;
  endfunction

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  task automatic tick();
    rec_t r;
    r = capture();
    @(posedge sys_clk);
    if (rst) begin
      q1.delete();
      q3.delete();
      repeat (2) q3.push_back('0);
      o1 = '0;
      o3 = '0;
    end else begin
      if (dflush) begin
        r = clr(r);
        foreach (q1[i]) q1[i] = clr(q1[i]);
        foreach (q3[i]) q3[i] = clr(q3[i]);
        o1 = clr(o1);
        o3 = clr(o3);
      end
      q1.push_back(r);
      q3.push_back(r);
      o1 = merge(o1, q1.pop_front());
      o3 = merge(o3, q3.pop_front());
      if (we && waddr < PG) mem[waddr] = wdata;
    end
    #1;
    for (int p = 0; p < P; p++) begin
      chk($sformatf("sb_lat1_p%0d", p), {vld1[p], err1[p], act_word(sh1, dl1, gt1, p)},
          {o1.vld[p], o1.err[p], o1.word[p*W +: W]});
      chk($sformatf("sb_lat3_p%0d", p), {vld3[p], err3[p], act_word(sh3, dl3, gt3, p)},
          {o3.vld[p], o3.err[p], o3.word[p*W +: W]});
    end
  endtask

  task automatic drive(logic r, logic [P-1:0] rq, logic [P*A-1:0] ra, logic w, logic [A-1:0] wa,
                       logic [W-1:0] wd, logic fl);
    rst = r; req = rq; raddr = ra; we = w; waddr = wa; wdata = wd; dflush = fl;
    tick();
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, '0, '0, 0, '0, '0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b1111, pk(0, 1, 2, 3),     0, 5'd0,  7'h00, 0};
    tbl[1] = '{4'b1111, pk(7, 7, 7, 7),     1, 5'd7,  7'h55, 0};
    tbl[2] = '{4'b0101, pk(19, 0, 20, 0),   0, 5'd0,  7'h00, 0};
    tbl[3] = '{4'b1010, pk(0, 31, 0, 4),    1, 5'd4,  7'h3C, 0};
    tbl[4] = '{4'b0000, pk(1, 1, 1, 1),     1, 5'd31, 7'h7F, 0};
    tbl[5] = '{4'b1111, pk(4, 7, 19, 24),   0, 5'd0,  7'h00, 1};
    tbl[6] = '{4'b0001, pk(12, 0, 0, 0),    1, 5'd12, 7'h09, 1};
    tbl[7] = '{4'b1100, pk(0, 0, 12, 12),   0, 5'd0,  7'h00, 0};
    tbl[8] = '{4'b1111, pk(19, 18, 17, 16), 1, 5'd18, 7'h2B, 0};
    tbl[9] = '{4'b0000, pk(0, 0, 0, 0),     0, 5'd0,  7'h00, 0};
    q3.push_back('0);
    q3.push_back('0);

    // reset then idle
    drive(1, '0, '0, 0, '0, '0, 0);
    drive(1, 4'b1111, pk(1, 2, 3, 4), 1, 5'd2, 7'h12, 1);
    idle(10);
    chk("idle_outputs", {vld1, err1, sh1, dl1, gt1}, '0);
    chk("idle_outputs_lat3", {vld3, err3, sh3, dl3, gt3}, '0);

    for (int i = 0; i < PG; i++) drive(0, '0, '0, 1, 5'(i), 7'((i * 37 + 5) & 7'h7F), 0);

    // basic read
    drive(0, '0, '0, 1, 5'd5, 7'b1_011_101, 0);
    drive(0, 4'b0001, pk(5, 0, 0, 0), 0, '0, '0, 0);
    chk("basic_read", {vld1[0], err1[0], gt1[0], dl1[2:0], sh1[2:0]}, {1'b1, 1'b0, 1'b1, 3'b011, 3'b101});

    // write-first bypass on two ports
    drive(0, '0, '0, 1, 5'd9, 7'h11, 0);
    drive(0, 4'b1001, pk(9, 0, 0, 9), 1, 5'd9, 7'h6A, 0);
    chk("bypass_p0", {vld1[0], act_word(sh1, dl1, gt1, 0)}, {1'b1, 7'h6A});
    chk("bypass_p3", {vld1[3], act_word(sh1, dl1, gt1, 3)}, {1'b1, 7'h6A});

    // out-of-range read and ignored write
    drive(0, 4'b0010, pk(0, 25, 0, 0), 0, '0, '0, 0);
    chk("range_err", {vld1[1], err1[1], act_word(sh1, dl1, gt1, 1)}, {1'b1, 1'b1, 7'h00});
    drive(0, '0, '0, 1, 5'd25, 7'h7F, 0);
    for (int i = 0; i < PG; i += 4) drive(0, 4'b1111, pk(i, i + 1, i + 2, i + 3), 0, '0, '0, 0);
    idle(3);

    // delta flush over three in-flight reads on the latency-3 instance
    drive(0, 4'b0001, pk(1, 0, 0, 0), 0, '0, '0, 0);
    drive(0, 4'b0001, pk(2, 0, 0, 0), 0, '0, '0, 0);
    drive(0, 4'b0001, pk(3, 0, 0, 0), 0, '0, '0, 1);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("delta_flush_pg%0d", k), {vld3[0], dl3[2:0], sh3[2:0], gt3[0]},
          {1'b1, 3'b000, mem[k][2:0], mem[k][6]});
      if (k < 3) idle(1);
    end
    idle(2);

    // reset one cycle after a request on the latency-3 instance
    drive(0, 4'b1111, pk(6, 7, 8, 9), 0, '0, '0, 0);
    drive(1, '0, '0, 0, '0, '0, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_mid_read_%0d", k), {vld3, err3, sh3, dl3, gt3}, '0);
      idle(1);
    end

    for (int i = 0; i < 10; i++) drive(0, tbl[i].req, tbl[i].raddr, tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].fl);

    for (int i = 0; i < 60; i++)
      drive(0, 4'($urandom), pk($urandom_range(0, 24), $urandom_range(0, 24), $urandom_range(0, 24), $urandom_range(0, 24)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 24)), 7'($urandom), $urandom_range(0, 7) == 0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
